uart_rx: RTL

//  UART receive stage. Consumes the 16x-oversampling tick from baud_gen and the raw rx pin.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx_sync_2ff.sv | 22 ++
 rtl/uart_rx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding, bit-timing constants, counter sizing.
// The transmitter reuses these definitions.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } state_e;

   localparam int unsigned START_MID = 7;
   localparam int unsigned BIT_LAST  = 15;

   // Two stop bits need 32 ticks, which needs a 5-bit tick counter.
   function automatic int unsigned cnt_width(int unsigned sb_tick);
      return (sb_tick > 16) ? 5 : 4;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side interface of the UART receiver: byte handshake plus status flags.
interface uart_rx_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 overrun;
   logic                 ovr_clr;
   logic                 busy;

   modport master (
      output rx_data, rx_valid, frame_err, overrun, busy,
      input  rx_ready, ovr_clr
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, overrun, busy,
      output rx_ready, ovr_clr
   );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset value.
module uart_rx_sync_2ff #(
   parameter int unsigned          WIDTH     = 1,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         q      <= RESET_VAL;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// UART receive stage: 16x oversampled frame recovery into a one-entry valid/ready buffer
// with framing and sticky overrun flags.
module uart_rx #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned SB_TICK   = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      tick,
   input  logic      rx,
   uart_rx_if.master bus
);
   import uart_rx_pkg::*;

   localparam int unsigned    CNT_W       = cnt_width(SB_TICK);
   localparam logic [CNT_W-1:0] START_MID_C = CNT_W'(START_MID);
   localparam logic [CNT_W-1:0] BIT_LAST_C  = CNT_W'(BIT_LAST);
   localparam logic [CNT_W-1:0] STOP_LAST_C = CNT_W'(SB_TICK - 1);
   localparam logic [2:0]       N_LAST_C    = 3'(DATA_BITS - 1);

   logic rx_s;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     s_cnt_q, s_cnt_d;
   logic [2:0]           n_cnt_q, n_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 deliver;
   logic                 stop_bad;
   logic                 busy;

   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_valid_q;
   logic                 frame_err_q;
   logic                 overrun_q;
   logic                 handshake;

   uart_rx_sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         s_cnt_q <= '0;
         n_cnt_q <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         s_cnt_q <= s_cnt_d;
         n_cnt_q <= n_cnt_d;
         shreg_q <= shreg_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      s_cnt_d  = s_cnt_q;
      n_cnt_d  = n_cnt_q;
      shreg_d  = shreg_q;
      deliver  = 1'b0;
      stop_bad = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Start detection does not wait for a tick.
            if (!rx_s) begin
               state_d = StStart;
               s_cnt_d = '0;
            end
         end
         StStart: begin
            if (tick) begin
               if (s_cnt_q == START_MID_C) begin
                  if (!rx_s) begin
                     state_d = StData;
                     s_cnt_d = '0;
                     n_cnt_d = '0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
         StData: begin
            if (tick) begin
               if (s_cnt_q == BIT_LAST_C) begin
                  s_cnt_d = '0;
                  shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                  if (n_cnt_q == N_LAST_C) begin
                     state_d = StStop;
                  end else begin
                     n_cnt_d = n_cnt_q + 3'd1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
         StStop: begin
            if (tick) begin
               if (s_cnt_q == STOP_LAST_C) begin
                  state_d  = StIdle;
                  deliver  = rx_s;
                  stop_bad = !rx_s;
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_comb begin
      busy = (state_q != StIdle);
   end

   assign handshake = rx_valid_q & bus.rx_ready;

   // A byte consumed in the delivery cycle frees the slot for the new byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= stop_bad;
         if (deliver && (!rx_valid_q || handshake)) begin
            rx_data_q  <= shreg_q;
            rx_valid_q <= 1'b1;
         end else if (handshake) begin
            rx_valid_q <= 1'b0;
         end
         if (deliver && rx_valid_q && !handshake) begin
            overrun_q <= 1'b1;
         end else if (bus.ovr_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
   assign bus.busy      = busy;

endmodule
